// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 definitions for the ysyx SRAM model: burst kinds, response codes and FSM states.
package ysyx_axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD    = 2'd1,
      WR    = 2'd2,
      BRESP = 2'd3
   } sram_state_e;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Decode error outranks a protocol error, which outranks success.
   function automatic logic [1:0] merge_resp(input logic dec, input logic slv);
      if (dec)      return RESP_DECERR;
      else if (slv) return RESP_SLVERR;
      else          return RESP_OKAY;
   endfunction

endpackage

// File: rtl/ysyx_axi_sram_lfsr.sv
// Wait-cycle generator for the SRAM model: 8-bit Fibonacci LFSR (taps 8,6,5,4), low 3 bits give 0-7 waits.
module ysyx_axi_sram_lfsr
   import ysyx_axi_pkg::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   output logic [2:0] wait_o
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign wait_o = lfsr_q[2:0];

endmodule

// File: rtl/ysyx_axi_sram.sv
// AXI4 slave SRAM model for standalone NPC simulation; one transaction in service at a time.
// Define YSYX_AXI_SRAM_DELAY_EN to add LFSR-driven wait cycles on responses and address acceptance.
module ysyx_axi_sram
   import ysyx_axi_pkg::*;
#(
   parameter int              XLEN  = 32,
   parameter logic [XLEN-1:0] BASE  = 32'h8000_0000,
   parameter int              DEPTH = 65536,
   parameter int              IDW   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        arburst,
   input  logic [2:0]        arsize,
   input  logic [7:0]        arlen,
   input  logic [IDW-1:0]    arid,
   input  logic [XLEN-1:0]   araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [IDW-1:0]    rid,
   output logic              rlast,
   output logic [XLEN-1:0]   rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   input  logic [1:0]        awburst,
   input  logic [2:0]        awsize,
   input  logic [7:0]        awlen,
   input  logic [IDW-1:0]    awid,
   input  logic [XLEN-1:0]   awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic              wlast,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN/8-1:0] wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [IDW-1:0]    bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready
);

   localparam int            AW   = $clog2(DEPTH);
   localparam int            SW   = XLEN / 8;
   localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH) << 2;

   function automatic logic in_range(input logic [XLEN-1:0] a);
      logic [XLEN-1:0] off;
      off = a - BASE;
      return (a >= BASE) && ({1'b0, off} < SPAN);
   endfunction

   function automatic logic [AW-1:0] widx(input logic [XLEN-1:0] a);
      return AW'((a - BASE) >> 2);
   endfunction

   logic [XLEN-1:0] mem [DEPTH];

   sram_state_e     state_q;
   logic [XLEN-1:0] addr_q;
   logic [7:0]      len_q;
   logic [7:0]      beat_q;
   logic [2:0]      size_q;
   burst_e          burst_q;
   logic            prio_rd_q;
   logic            dec_q;
   logic            slv_q;
   logic [2:0]      wait_q;

   logic            rvalid_q;
   logic            rlast_q;
   logic [XLEN-1:0] rdata_q;
   logic [1:0]      rresp_q;
   logic [IDW-1:0]  rid_q;
   logic            bvalid_q;
   logic [1:0]      bresp_q;
   logic [IDW-1:0]  bid_q;

   logic [XLEN-1:0] addr_d;
   logic [XLEN-1:0] rd_addr;
   logic [XLEN-1:0] rd_data_d;
   logic [1:0]      rd_resp_d;
   logic            ar_grant;
   logic            aw_grant;
   logic            idle_open;
   logic            w_dec;
   logic            w_slv;
   logic            mem_we;
   logic [2:0]      wait_ld;

`ifdef YSYX_AXI_SRAM_DELAY_EN
   ysyx_axi_sram_lfsr u_lfsr (
      .clock_i (clock),
      .reset_i (reset),
      .wait_o  (wait_ld)
   );
`else
   assign wait_ld = 3'd0;
`endif

   // Contended cycles go to the channel not serviced last; an uncontended request always wins.
   assign ar_grant  = arvalid && (!awvalid || prio_rd_q);
   assign aw_grant  = awvalid && !ar_grant;
   assign idle_open = (state_q == IDLE) && (wait_q == 3'd0);
   assign arready   = idle_open && ar_grant;
   assign awready   = idle_open && aw_grant;
   assign wready    = (state_q == WR);

   assign rvalid = rvalid_q;
   assign rlast  = rlast_q;
   assign rdata  = rdata_q;
   assign rresp  = rresp_q;
   assign rid    = rid_q;
   assign bvalid = bvalid_q;
   assign bresp  = bresp_q;
   assign bid    = bid_q;

   always_comb begin
      addr_d = addr_q;
      if (burst_q != BURST_FIXED) addr_d = addr_q + (XLEN'(1) << size_q);
   end

   // The read port looks at the incoming AR address in IDLE and at the next beat address in RD.
   always_comb begin
      rd_addr   = (state_q == IDLE) ? araddr : addr_d;
      rd_data_d = '0;
      rd_resp_d = RESP_DECERR;
      if (in_range(rd_addr)) begin
         rd_data_d = mem[widx(rd_addr)];
         rd_resp_d = RESP_OKAY;
      end
   end

   assign w_dec  = !in_range(addr_q);
   assign w_slv  = wlast != (beat_q == len_q);
   assign mem_we = (state_q == WR) && wvalid && !w_dec;

   // NOTE: the array has no reset; like a real SRAM its contents are undefined until written.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < SW; b++) begin
            if (wstrb[b]) mem[widx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         size_q    <= '0;
         burst_q   <= BURST_FIXED;
         prio_rd_q <= 1'b1;
         dec_q     <= 1'b0;
         slv_q     <= 1'b0;
         wait_q    <= '0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rid_q     <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         bid_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wait_q != 3'd0) begin
                  wait_q <= wait_q - 3'd1;
               end else if (arvalid && arready) begin
                  state_q   <= RD;
                  addr_q    <= araddr;
                  len_q     <= arlen;
                  size_q    <= arsize;
                  burst_q   <= burst_e'(arburst);
                  rid_q     <= arid;
                  beat_q    <= '0;
                  prio_rd_q <= 1'b0;
                  rdata_q   <= rd_data_d;
                  rresp_q   <= rd_resp_d;
                  rlast_q   <= (arlen == 8'd0);
                  if (wait_ld == 3'd0) rvalid_q <= 1'b1;
                  else                 wait_q   <= wait_ld - 3'd1;
               end else if (awvalid && awready) begin
                  state_q   <= WR;
                  addr_q    <= awaddr;
                  len_q     <= awlen;
                  size_q    <= awsize;
                  burst_q   <= burst_e'(awburst);
                  bid_q     <= awid;
                  beat_q    <= '0;
                  dec_q     <= 1'b0;
                  slv_q     <= 1'b0;
                  prio_rd_q <= 1'b1;
               end
            end
            RD: begin
               if (!rvalid_q) begin
                  if (wait_q == 3'd0) rvalid_q <= 1'b1;
                  else                wait_q   <= wait_q - 3'd1;
               end else if (rready) begin
                  if (rlast_q) begin
                     rvalid_q <= 1'b0;
                     rlast_q  <= 1'b0;
                     state_q  <= IDLE;
                     wait_q   <= wait_ld;
                  end else begin
                     beat_q  <= beat_q + 8'd1;
                     addr_q  <= addr_d;
                     rdata_q <= rd_data_d;
                     rresp_q <= rd_resp_d;
                     rlast_q <= (beat_q + 8'd1 == len_q);
                     if (wait_ld != 3'd0) begin
                        rvalid_q <= 1'b0;
                        wait_q   <= wait_ld - 3'd1;
                     end
                  end
               end
            end
            WR: begin
               if (wvalid) begin
                  if (beat_q == len_q) begin
                     state_q <= BRESP;
                     bresp_q <= merge_resp(dec_q | w_dec, slv_q | w_slv);
                     if (wait_ld == 3'd0) bvalid_q <= 1'b1;
                     else                 wait_q   <= wait_ld - 3'd1;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                     addr_q <= addr_d;
                     dec_q  <= dec_q | w_dec;
                     slv_q  <= slv_q | w_slv;
                  end
               end
            end
            BRESP: begin
               if (!bvalid_q) begin
                  if (wait_q == 3'd0) bvalid_q <= 1'b1;
                  else                wait_q   <= wait_q - 3'd1;
               end else if (bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= IDLE;
                  wait_q   <= wait_ld;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_axi_sram.sv
// Scoreboard bench for ysyx_axi_sram: expected beats/responses are queued at issue and popped on output.
module tb_ysyx_axi_sram;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 65536;
   localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);
   localparam int          BOUND = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  arburst = '0;
   logic [2:0]  arsize = '0;
   logic [7:0]  arlen = '0;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  rid;
   logic        rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [1:0]  awburst = '0;
   logic [2:0]  awsize = '0;
   logic [7:0]  awlen = '0;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic        wlast = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;

   always #5 clock = ~clock;

   ysyx_axi_sram dut (
      .clock(clock), .reset(reset),
      .arburst(arburst), .arsize(arsize), .arlen(arlen), .arid(arid), .araddr(araddr),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rlast(rlast), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awburst(awburst), .awsize(awsize), .awlen(awlen), .awid(awid), .awaddr(awaddr),
      .awvalid(awvalid), .awready(awready),
      .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rbeat_t;

   typedef struct packed {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   rbeat_t      rq[$];
   bexp_t       bq[$];
   logic [31:0] model [int];
   logic [31:0] wbuf_data [16];
   logic [3:0]  wbuf_strb [16];
   logic        wbuf_last [16];

   function automatic logic mod_in_range(input logic [31:0] a);
      return (a >= BASE) && (a < TOP);
   endfunction

   function automatic int mod_idx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] mod_next(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [2:0] size);
      return (burst == 2'd0) ? a : a + (32'd1 << size);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id);
      logic [31:0] a;
      rbeat_t      e;
      int          n;
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         e.data = (mod_in_range(a) && model.exists(mod_idx(a))) ? model[mod_idx(a)] : 32'd0;
         e.resp = mod_in_range(a) ? 2'b00 : 2'b11;
         e.last = (i == int'(len));
         e.id   = id;
         rq.push_back(e);
         a = mod_next(a, burst, size);
      end
      araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
      #1;
      n = 0;
      while (arready !== 1'b1 && n < BOUND) begin
         @(posedge clock);
         #2;
         n++;
      end
      checks++;
      if (n >= BOUND) begin
         errors++;
         $display("FAIL ar_handshake: arready=%b, expected 1 within %0d cycles", arready, BOUND);
      end
      @(posedge clock);
      #1;
      arvalid = 1'b0;
   endtask

   task automatic r_collect(input int nbeats, output int cycles);
      rbeat_t e;
      int     n;
      cycles = 0;
      rready = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         n = 0;
         while (rvalid !== 1'b1 && n < BOUND) begin
            tick();
            n++;
         end
         checks++;
         if (n >= BOUND || rq.size() == 0) begin
            errors++;
            $display("FAIL r_beat%0d: rvalid=%b with %0d beats expected", i, rvalid, rq.size());
         end else begin
            e = rq.pop_front();
            if ({rdata, rresp, rlast, rid} !== e) begin
               errors++;
               $display("FAIL r_beat%0d: got data=%h resp=%b last=%b id=%h, want data=%h resp=%b last=%b id=%h",
                        i, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
            end
         end
         tick();
         cycles += n + 1;
      end
      rready = 1'b0;
   endtask

   task automatic b_collect();
      bexp_t e;
      int    n;
      bready = 1'b1;
      n = 0;
      while (bvalid !== 1'b1 && n < BOUND) begin
         tick();
         n++;
      end
      checks++;
      if (n >= BOUND || bq.size() == 0) begin
         errors++;
         $display("FAIL b_resp: bvalid=%b with %0d responses expected", bvalid, bq.size());
      end else begin
         e = bq.pop_front();
         if ({bresp, bid} !== e) begin
            errors++;
            $display("FAIL b_resp: got bresp=%b bid=%h, want bresp=%b bid=%h", bresp, bid, e.resp, e.id);
         end
      end
      tick();
      bready = 1'b0;
   endtask

   task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id);
      logic [31:0] a;
      logic [31:0] w;
      logic        dec;
      logic        slv;
      bexp_t       e;
      int          n;
      a = addr; dec = 1'b0; slv = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         if (mod_in_range(a)) begin
            w = model.exists(mod_idx(a)) ? model[mod_idx(a)] : 32'd0;
            for (int b = 0; b < 4; b++) begin
               if (wbuf_strb[i][b]) w[8*b +: 8] = wbuf_data[i][8*b +: 8];
            end
            model[mod_idx(a)] = w;
         end else begin
            dec = 1'b1;
         end
         if (wbuf_last[i] != (i == int'(len))) slv = 1'b1;
         a = mod_next(a, burst, size);
      end
      e.resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
      e.id   = id;
      bq.push_back(e);

      awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
      #1;
      n = 0;
      while (awready !== 1'b1 && n < BOUND) begin
         @(posedge clock);
         #2;
         n++;
      end
      checks++;
      if (n >= BOUND) begin
         errors++;
         $display("FAIL aw_handshake: awready=%b, expected 1 within %0d cycles", awready, BOUND);
      end
      @(posedge clock);
      #1;
      awvalid = 1'b0;

      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = wbuf_strb[i]; wlast = wbuf_last[i];
         n = 0;
         while (wready !== 1'b1 && n < BOUND) begin
            tick();
            n++;
         end
         if (n >= BOUND) begin
            checks++;
            errors++;
            $display("FAIL w_beat%0d: wready=%b, expected 1 within %0d cycles", i, wready, BOUND);
         end
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      b_collect();
   endtask

   task automatic set_single(input logic [31:0] d, input logic [3:0] s);
      wbuf_data[0] = d; wbuf_strb[0] = s; wbuf_last[0] = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ar/aw/w ready, r/b valid, rlast = %b, want 000000",
                  {arready, awready, wready, rvalid, bvalid, rlast});
      end
      checks++;
      if ({rdata, rresp, bresp, rid, bid} !== '0) begin
         errors++;
         $display("FAIL reset_payload: rdata=%h rresp=%b bresp=%b rid=%h bid=%h, want all 0",
                  rdata, rresp, bresp, rid, bid);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int cyc;
      set_single(32'hDEAD_BEEF, 4'hF);
      wr_burst(BASE, 8'd0, 2'd1, 3'd2, 4'h3);
      ar_issue(BASE, 8'd0, 2'd1, 3'd2, 4'h5);
      checks++;
      if (rvalid !== 1'b1) begin
         errors++;
         $display("FAIL read_latency: rvalid=%b one cycle after AR handshake, want 1", rvalid);
      end
      r_collect(1, cyc);
   endtask

   task automatic test_strobe();
      int cyc;
      set_single(32'h1122_3344, 4'hF);
      wr_burst(BASE + 32'h8, 8'd0, 2'd1, 3'd2, 4'h1);
      set_single(32'hAA00_0000, 4'b1000);
      wr_burst(BASE + 32'h8, 8'd0, 2'd1, 3'd2, 4'h2);
      ar_issue(BASE + 32'h8, 8'd0, 2'd1, 3'd2, 4'h4);
      r_collect(1, cyc);
   endtask

   task automatic test_incr_burst();
      int cyc;
      for (int i = 0; i < 4; i++) begin
         wbuf_data[i] = 32'hC0DE_0000 + 32'(i);
         wbuf_strb[i] = 4'hF;
         wbuf_last[i] = (i == 3);
      end
      wr_burst(BASE + 32'h10, 8'd3, 2'd1, 3'd2, 4'h6);
      ar_issue(BASE + 32'h10, 8'd3, 2'd1, 3'd2, 4'h7);
      r_collect(4, cyc);
      checks++;
      if (cyc !== 4) begin
         errors++;
         $display("FAIL incr_back_to_back: 4 beats took %0d cycles, want 4", cyc);
      end
   endtask

   task automatic test_fixed_burst();
      int cyc;
      ar_issue(BASE + 32'h14, 8'd2, 2'd0, 3'd2, 4'h9);
      r_collect(3, cyc);
   endtask

   task automatic test_out_of_range();
      int cyc;
      ar_issue(32'h7FFF_FFFC, 8'd0, 2'd1, 3'd2, 4'hA);
      r_collect(1, cyc);
      set_single(32'h1234_5678, 4'hF);
      wr_burst(TOP, 8'd0, 2'd1, 3'd2, 4'hB);
      ar_issue(BASE, 8'd0, 2'd1, 3'd2, 4'hC);
      r_collect(1, cyc);
   endtask

   task automatic test_top_crossing();
      int cyc;
      set_single(32'hCAFE_F00D, 4'hF);
      wr_burst(TOP - 32'd4, 8'd0, 2'd1, 3'd2, 4'hD);
      ar_issue(TOP - 32'd4, 8'd1, 2'd1, 3'd2, 4'hE);
      r_collect(2, cyc);
   endtask

   task automatic test_stall();
      int cyc;
      ar_issue(BASE + 32'h10, 8'd1, 2'd1, 3'd2, 4'h2);
      rready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (rvalid !== 1'b1 || rdata !== rq[0].data || rlast !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: rvalid=%b rdata=%h rlast=%b, want 1 %h 0",
                     c, rvalid, rdata, rlast, rq[0].data);
         end
         tick();
      end
      r_collect(2, cyc);
   endtask

   task automatic test_early_wlast();
      for (int i = 0; i < 3; i++) begin
         wbuf_data[i] = 32'h5A5A_0000 + 32'(i);
         wbuf_strb[i] = 4'hF;
         wbuf_last[i] = (i >= 1);
      end
      wr_burst(BASE + 32'h30, 8'd2, 2'd1, 3'd2, 4'h5);
   endtask

   task automatic test_arbitration();
      int   cyc;
      logic exp_rd;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int r = 0; r < 4; r++) begin
         exp_rd = (r % 2 == 0);
         araddr = BASE; arlen = 8'd0; arburst = 2'd1; arsize = 3'd2; arid = 4'h1; arvalid = 1'b1;
         awaddr = BASE + 32'h20; awlen = 8'd0; awburst = 2'd1; awsize = 3'd2; awid = 4'h2;
         awvalid = 1'b1;
         #1;
         checks++;
         if ({arready, awready} !== {exp_rd, !exp_rd}) begin
            errors++;
            $display("FAIL arb_round%0d: arready=%b awready=%b, want %b %b",
                     r, arready, awready, exp_rd, !exp_rd);
         end
         arvalid = 1'b0;
         awvalid = 1'b0;
         #1;
         if (exp_rd) begin
            ar_issue(BASE, 8'd0, 2'd1, 3'd2, 4'h1);
            r_collect(1, cyc);
         end else begin
            set_single(32'h0BAD_0000 + 32'(r), 4'hF);
            wr_burst(BASE + 32'h20, 8'd0, 2'd1, 3'd2, 4'h2);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      ar_issue(BASE + 32'h10, 8'd3, 2'd1, 3'd2, 4'h1);
      rready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rq.delete();
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_rvalid: rvalid=%b after reset edge, want 0", rvalid);
      end
      araddr = BASE; arlen = 8'd0; arvalid = 1'b1;
      #1;
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_idle: arready=%b after reset, want 1", arready);
      end
      arvalid = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_strobe();
      test_incr_burst();
      test_fixed_burst();
      test_out_of_range();
      test_top_crossing();
      test_stall();
      test_early_wlast();
      test_arbitration();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
